// File: rtl/fat32_mount_sequencer.sv
// FAT32 mount sequencer: reads sector 0 (MBR or superfloppy boot sector),
// optionally the partition's volume boot record, validates the BPB and
// derives the FAT and data-region start sectors.
module fat32_mount_sequencer #(
  parameter int unsigned SECTOR_BYTES   = 512,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        Clock,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        rd_req,
  output logic [31:0] rd_sector,
  input  logic        rd_ack,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        busy,
  output logic        mounted,
  output logic        mount_error,
  output logic [2:0]  error_code,
  output logic [31:0] partition_lba,
  output logic [31:0] fat_start_sector,
  output logic [31:0] data_start_sector,
  output logic [31:0] root_cluster,
  output logic [7:0]  sectors_per_cluster
);

  localparam int unsigned OFF_W  = 10;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ERR_SIG     = 3'd1;
  localparam logic [2:0] ERR_NOFS    = 3'd2;
  localparam logic [2:0] ERR_BPS     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_GEOM    = 3'd5;

  typedef enum logic [3:0] {
    IDLE, REQ_S0, RX_S0, CHK_S0, REQ_VBR, RX_VBR, CHK_VBR, CALC, DONE, ERR
  } state_e;

  state_e              state_q;
  logic [OFF_W-1:0]    off_q;
  logic [IDLE_W-1:0]   idle_q;

  // Fields captured from the sector stream
  logic [7:0]  jump_q;
  logic [7:0]  ptype_q;
  logic [31:0] lba_cap_q;
  logic [7:0]  sig_lo_q;
  logic [7:0]  sig_hi_q;
  logic [15:0] bps_q;
  logic [7:0]  spc_q;
  logic [15:0] rsvd_q;
  logic [7:0]  nf_q;
  logic [31:0] fsz_q;
  logic [31:0] root_q;
  logic [31:0] plba_q;

  logic        sig_ok_c;
  logic        mbr_c;
  logic        sfloppy_c;
  logic        last_byte_c;
  logic        fail_c;
  logic [2:0]  fail_code_c;
  logic [31:0] fat_start_d;
  logic [31:0] data_start_d;

  assign sig_ok_c     = (sig_lo_q == 8'h55) && (sig_hi_q == 8'hAA);
  assign mbr_c        = (ptype_q == 8'h0B) || (ptype_q == 8'h0C);
  assign sfloppy_c    = (jump_q == 8'hEB) || (jump_q == 8'hE9);
  assign last_byte_c  = (off_q == OFF_W'(SECTOR_BYTES - 1));
  assign fat_start_d  = plba_q + 32'(rsvd_q);
  assign data_start_d = fat_start_d + 32'(nf_q) * fsz_q;

  // Failure detection for the current state, in priority order
  always_comb begin
    fail_c      = 1'b0;
    fail_code_c = 3'd0;
    case (state_q)
      RX_S0, RX_VBR: begin
        if (!byte_valid && (idle_q == IDLE_W'(TIMEOUT_CYCLES))) begin
          fail_c      = 1'b1;
          fail_code_c = ERR_TIMEOUT;
        end
      end
      CHK_S0: begin
        if (!sig_ok_c) begin
          fail_c      = 1'b1;
          fail_code_c = ERR_SIG;
        end else if (!mbr_c && !sfloppy_c) begin
          fail_c      = 1'b1;
          fail_code_c = ERR_NOFS;
        end
      end
      CHK_VBR: begin
        if (!sig_ok_c) begin
          fail_c      = 1'b1;
          fail_code_c = ERR_SIG;
        end else if (bps_q != 16'(SECTOR_BYTES)) begin
          fail_c      = 1'b1;
          fail_code_c = ERR_BPS;
        end else if ((spc_q == 8'd0) || (nf_q == 8'd0)) begin
          fail_c      = 1'b1;
          fail_code_c = ERR_GEOM;
        end
      end
      default: ;
    endcase
  end

  // Mount FSM with registered outputs and stream field capture
  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q             <= IDLE;
      off_q               <= '0;
      idle_q              <= '0;
      jump_q              <= '0;
      ptype_q             <= '0;
      lba_cap_q           <= '0;
      sig_lo_q            <= '0;
      sig_hi_q            <= '0;
      bps_q               <= '0;
      spc_q               <= '0;
      rsvd_q              <= '0;
      nf_q                <= '0;
      fsz_q               <= '0;
      root_q              <= '0;
      plba_q              <= '0;
      rd_req              <= 1'b0;
      rd_sector           <= '0;
      busy                <= 1'b0;
      mounted             <= 1'b0;
      mount_error         <= 1'b0;
      error_code          <= '0;
      partition_lba       <= '0;
      fat_start_sector    <= '0;
      data_start_sector   <= '0;
      root_cluster        <= '0;
      sectors_per_cluster <= '0;
    end else if (fail_c) begin
      state_q             <= ERR;
      busy                <= 1'b0;
      mount_error         <= 1'b1;
      error_code          <= fail_code_c;
      rd_req              <= 1'b0;
      partition_lba       <= '0;
      fat_start_sector    <= '0;
      data_start_sector   <= '0;
      root_cluster        <= '0;
      sectors_per_cluster <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q     <= REQ_S0;
            busy        <= 1'b1;
            mounted     <= 1'b0;
            mount_error <= 1'b0;
            error_code  <= '0;
            rd_req      <= 1'b1;
            rd_sector   <= '0;
          end
        end
        REQ_S0, REQ_VBR: begin
          if (rd_ack) begin
            state_q <= (state_q == REQ_S0) ? RX_S0 : RX_VBR;
            rd_req  <= 1'b0;
            off_q   <= '0;
            idle_q  <= '0;
          end
        end
        RX_S0, RX_VBR: begin
          if (byte_valid) begin
            idle_q <= '0;
            off_q  <= off_q + OFF_W'(1);
            case (off_q)
              10'h000: jump_q          <= byte_data;
              10'h00B: bps_q[7:0]      <= byte_data;
              10'h00C: bps_q[15:8]     <= byte_data;
              10'h00D: spc_q           <= byte_data;
              10'h00E: rsvd_q[7:0]     <= byte_data;
              10'h00F: rsvd_q[15:8]    <= byte_data;
              10'h010: nf_q            <= byte_data;
              10'h024: fsz_q[7:0]      <= byte_data;
              10'h025: fsz_q[15:8]     <= byte_data;
              10'h026: fsz_q[23:16]    <= byte_data;
              10'h027: fsz_q[31:24]    <= byte_data;
              10'h02C: root_q[7:0]     <= byte_data;
              10'h02D: root_q[15:8]    <= byte_data;
              10'h02E: root_q[23:16]   <= byte_data;
              10'h02F: root_q[31:24]   <= byte_data;
              10'h1C2: ptype_q         <= byte_data;
              10'h1C6: lba_cap_q[7:0]  <= byte_data;
              10'h1C7: lba_cap_q[15:8] <= byte_data;
              10'h1C8: lba_cap_q[23:16] <= byte_data;
              10'h1C9: lba_cap_q[31:24] <= byte_data;
              10'h1FE: sig_lo_q        <= byte_data;
              10'h1FF: sig_hi_q        <= byte_data;
              default: ;
            endcase
            if (last_byte_c) begin
              state_q <= (state_q == RX_S0) ? CHK_S0 : CHK_VBR;
            end
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        CHK_S0: begin
          if (mbr_c) begin
            plba_q    <= lba_cap_q;
            rd_sector <= lba_cap_q;
            rd_req    <= 1'b1;
            state_q   <= REQ_VBR;
          end else begin
            // Superfloppy: the BPB fields were captured during this same pass
            plba_q  <= '0;
            state_q <= CHK_VBR;
          end
        end
        CHK_VBR: state_q <= CALC;
        CALC: begin
          partition_lba       <= plba_q;
          fat_start_sector    <= fat_start_d;
          data_start_sector   <= data_start_d;
          root_cluster        <= root_q;
          sectors_per_cluster <= spc_q;
          mounted             <= 1'b1;
          busy                <= 1'b0;
          state_q             <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fat32_mount_sequencer.sv
// Self-checking bench for fat32_mount_sequencer: a sector reader model serves
// byte images, and a behavioural model derives the expected mount result.
module tb_fat32_mount_sequencer;

  localparam int unsigned SB = 512;
  localparam int unsigned TO = 200;

  logic        Clock = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rd_ack = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        rd_req;
  logic [31:0] rd_sector;
  logic        busy;
  logic        mounted;
  logic        mount_error;
  logic [2:0]  error_code;
  logic [31:0] partition_lba;
  logic [31:0] fat_start_sector;
  logic [31:0] data_start_sector;
  logic [31:0] root_cluster;
  logic [7:0]  sectors_per_cluster;

  fat32_mount_sequencer #(.SECTOR_BYTES(SB), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .start(start),
    .rd_req(rd_req), .rd_sector(rd_sector), .rd_ack(rd_ack),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .busy(busy), .mounted(mounted), .mount_error(mount_error), .error_code(error_code),
    .partition_lba(partition_lba), .fat_start_sector(fat_start_sector),
    .data_start_sector(data_start_sector), .root_cluster(root_cluster),
    .sectors_per_cluster(sectors_per_cluster)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  s0  [SB];
  logic [7:0]  vbr [SB];
  logic [31:0] rd_log [$];
  logic [31:0] exp_reads [$];
  int          exp_code;
  logic [31:0] exp_plba, exp_fat, exp_data, exp_root;
  logic [7:0]  exp_spc;

  // Sector image helpers (little-endian fields)
  task automatic put(input bit which, input int off, input int n, input logic [31:0] v);
    for (int k = 0; k < n; k++) begin
      if (which) vbr[off+k] = v[8*k +: 8];
      else       s0[off+k]  = v[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] get(input bit which, input int off, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = which ? vbr[off+k] : s0[off+k];
    return r;
  endfunction

  task automatic fill_rand(input bit which);
    for (int i = 0; i < int'(SB); i++) begin
      if (which) vbr[i] = 8'($urandom);
      else       s0[i]  = 8'($urandom);
    end
  endtask

  task automatic put_bpb(input bit which, input logic [15:0] bps, input logic [7:0] spc,
                         input logic [15:0] rsvd, input logic [7:0] nf,
                         input logic [31:0] fsz, input logic [31:0] root);
    put(which, 11, 2, 32'(bps));
    put(which, 13, 1, 32'(spc));
    put(which, 14, 2, 32'(rsvd));
    put(which, 16, 1, 32'(nf));
    put(which, 36, 4, fsz);
    put(which, 44, 4, root);
    put(which, 510, 2, 32'h0000_AA55);
  endtask

  task automatic build_mbr(input logic [7:0] ptype, input logic [31:0] lba);
    fill_rand(0);
    s0[450] = ptype;
    put(0, 454, 4, lba);
    put(0, 510, 2, 32'h0000_AA55);
  endtask

  // Reference: mount outcome computed directly from the two sector images
  task automatic model();
    bit src;
    exp_reads.delete();
    exp_reads.push_back(32'd0);
    exp_code = 0; exp_plba = '0; exp_fat = '0; exp_data = '0; exp_root = '0; exp_spc = '0;
    if (get(0, 510, 2) != 32'hAA55) begin exp_code = 1; return; end
    if (s0[450] == 8'h0B || s0[450] == 8'h0C) begin
      exp_plba = get(0, 454, 4);
      exp_reads.push_back(exp_plba);
      src = 1;
    end else if (s0[0] == 8'hEB || s0[0] == 8'hE9) begin
      src = 0;
    end else begin
      exp_code = 2; return;
    end
    if (get(src, 510, 2) != 32'hAA55)                 exp_code = 1;
    else if (get(src, 11, 2) != SB)                   exp_code = 3;
    else if (get(src, 13, 1) == 0 || get(src, 16, 1) == 0) exp_code = 5;
    else begin
      exp_fat  = exp_plba + get(src, 14, 2);
      exp_data = exp_fat + get(src, 16, 1) * get(src, 36, 4);
      exp_root = get(src, 44, 4);
      exp_spc  = 8'(get(src, 13, 1));
    end
  endtask

  function automatic logic [140:0] obs();
    return {mounted, mount_error, error_code, partition_lba, fat_start_sector,
            data_start_sector, root_cluster, sectors_per_cluster};
  endfunction

  function automatic logic [140:0] expv();
    if (exp_code == 0) return {1'b1, 1'b0, 3'd0, exp_plba, exp_fat, exp_data, exp_root, exp_spc};
    return {1'b0, 1'b1, 3'(exp_code), 136'd0};
  endfunction

  function automatic logic [95:0] pack_reads(input logic [31:0] q [$]);
    return {32'(q.size()), (q.size() > 0) ? q[0] : 32'd0, (q.size() > 1) ? q[1] : 32'd0};
  endfunction

  // Reader model: streams one sector, with optional halt, reset, stray start or long gap
  task automatic stream(input int rd_idx, input int halt_after, input int rst_at,
                        input int start_at, input int longgap_at);
    int gap;
    for (int i = 0; i < int'(SB); i++) begin
      if (rd_idx == 0 && i == halt_after) return;
      if (rd_idx == 1 && i == rst_at) begin
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_req, rd_sector, busy, obs()} !== '0) begin
          errors++;
          $display("FAIL reset_mid_stream: outputs %h required all zero", {rd_req, rd_sector, busy, obs()});
        end
        @(negedge Clock);
        sys_rst_n = 1'b1;
        return;
      end
      if (rd_idx == 0 && i == longgap_at) gap = int'(TO);
      else gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      repeat (gap) @(negedge Clock);
      if (rd_idx == 0 && i == start_at) begin
        start = 1'b1; @(negedge Clock); start = 1'b0;
      end
      byte_data  = rd_idx ? vbr[i] : s0[i];
      byte_valid = 1'b1;
      @(negedge Clock);
      byte_valid = 1'b0;
    end
  endtask

  // Pulse start and serve read requests until the sequencer goes idle
  task automatic do_mount(input int halt_after, input int rst_at, input int start_at, input int longgap_at);
    int cyc = 0;
    int nrd = 0;
    rd_log.delete();
    start = 1'b1; @(negedge Clock); start = 1'b0;
    while (busy && cyc < 30000) begin
      if (rd_req) begin
        rd_log.push_back(rd_sector);
        repeat ($urandom_range(0, 4)) begin @(negedge Clock); cyc++; end
        rd_ack = 1'b1; @(negedge Clock); rd_ack = 1'b0;
        stream(nrd, halt_after, rst_at, start_at, longgap_at);
        nrd++;
      end else begin
        @(negedge Clock);
        cyc++;
      end
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL mount_completion: busy still %b after %0d cycles, required 0", busy, cyc);
    end
  endtask

  task automatic test_reset();
    bit saw = 0;
    #1;
    checks++;
    if ({rd_req, rd_sector, busy, obs()} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs %h required all zero", {rd_req, rd_sector, busy, obs()});
    end
    repeat (3) @(negedge Clock);
    sys_rst_n = 1'b1;
    rd_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      byte_valid = 1'($urandom); byte_data = 8'($urandom);
      @(negedge Clock);
      saw |= rd_req | busy;
    end
    rd_ack = 1'b0; byte_valid = 1'b0;
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_read: rd_req/busy seen %b without start, required 0", saw);
    end
  endtask

  task automatic test_mbr();
    build_mbr(8'h0C, 32'h0000_2000);
    fill_rand(1);
    put_bpb(1, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
    model();
    do_mount(-1, -1, 50, -1);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL mbr_model: got %h required %h", obs(), expv());
    end
    checks++;
    if ({mounted, fat_start_sector, data_start_sector} !== {1'b1, 32'h2020, 32'h27A2}) begin
      errors++;
      $display("FAIL mbr_geometry: got %b %h %h required 1 00002020 000027a2", mounted, fat_start_sector, data_start_sector);
    end
    checks++;
    if (pack_reads(rd_log) !== {32'd2, 32'd0, 32'h2000}) begin
      errors++; $display("FAIL mbr_reads: got %h required 2 reads 0,2000", pack_reads(rd_log));
    end
  endtask

  task automatic test_superfloppy();
    fill_rand(0);
    put_bpb(0, 16'd512, 8'd4, 16'd32, 8'd2, 32'h100, 32'd2);
    s0[0] = 8'hEB; s0[450] = 8'h00;
    do_mount(-1, -1, -1, -1);
    checks++;
    if ({mounted, partition_lba, data_start_sector} !== {1'b1, 32'd0, 32'h220}) begin
      errors++;
      $display("FAIL superfloppy_geometry: got %b %h %h required 1 00000000 00000220", mounted, partition_lba, data_start_sector);
    end
    checks++;
    if (pack_reads(rd_log) !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL superfloppy_reads: got %h required 1 read of 0", pack_reads(rd_log));
    end
  endtask

  task automatic test_bad_signature();
    s0[511] = 8'h00;
    do_mount(-1, -1, -1, -1);
    checks++;
    if (obs() !== {1'b0, 1'b1, 3'd1, 136'd0}) begin
      errors++; $display("FAIL bad_signature: got %h required error code 1", obs());
    end
    checks++;
    if (pack_reads(rd_log) !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL bad_signature_reads: got %h required 1 read", pack_reads(rd_log));
    end
  endtask

  task automatic test_timeout();
    build_mbr(8'h0B, 32'h0000_0800);
    fill_rand(1);
    put_bpb(1, 16'd512, 8'd16, 16'd6, 8'd1, 32'h1234, 32'd5);
    do_mount(100, -1, -1, -1);
    checks++;
    if (obs() !== {1'b0, 1'b1, 3'd4, 136'd0}) begin
      errors++; $display("FAIL timeout: got %h required error code 4", obs());
    end
    model();
    do_mount(-1, -1, -1, -1);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL remount_after_timeout: got %h required %h", obs(), expv());
    end
  endtask

  task automatic test_timeout_boundary();
    model();
    do_mount(-1, -1, -1, 200);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL timeout_boundary: got %h required %h", obs(), expv());
    end
  endtask

  task automatic test_reset_mid();
    model();
    do_mount(-1, 300, -1, -1);
    checks++;
    if (rd_log.size() !== 2) begin
      errors++; $display("FAIL reset_reached_vbr: %0d reads required 2", rd_log.size());
    end
    do_mount(-1, -1, -1, -1);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL remount_after_reset: got %h required %h", obs(), expv());
    end
    checks++;
    if (pack_reads(rd_log) !== pack_reads(exp_reads)) begin
      errors++; $display("FAIL remount_reads: got %h required %h", pack_reads(rd_log), pack_reads(exp_reads));
    end
  endtask

  task automatic test_random();
    int mode;
    logic [7:0] spc, nf;
    for (int it = 0; it < 8; it++) begin
      mode = int'($urandom_range(0, 6));
      spc  = 8'(1 << $urandom_range(0, 7));
      nf   = 8'($urandom_range(1, 3));
      if (mode == 1) begin
        fill_rand(0);
        put_bpb(0, 16'd512, spc, 16'($urandom), nf, $urandom, $urandom);
        s0[0] = ($urandom_range(0, 1) == 0) ? 8'hEB : 8'hE9;
        s0[450] = 8'h83;
      end else if (mode == 3) begin
        fill_rand(0);
        put(0, 510, 2, 32'h0000_AA55);
        if (s0[450] == 8'h0B || s0[450] == 8'h0C) s0[450] = 8'h07;
        if (s0[0] == 8'hEB || s0[0] == 8'hE9) s0[0] = 8'h00;
      end else begin
        build_mbr(($urandom_range(0, 1) == 0) ? 8'h0B : 8'h0C, 32'($urandom_range(1, 32'h00FF_FFFF)));
        fill_rand(1);
        put_bpb(1, 16'd512, spc, 16'($urandom), nf, $urandom, $urandom);
        if (mode == 2) s0[511] = 8'h00;
        if (mode == 4) put(1, 11, 2, 32'(16'd4096));
        if (mode == 5) begin
          if ($urandom_range(0, 1) == 0) vbr[13] = 8'h00; else vbr[16] = 8'h00;
        end
        if (mode == 6) vbr[510] = 8'h54;
      end
      model();
      do_mount(-1, -1, -1, -1);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random_%0d_mode%0d: got %h required %h", it, mode, obs(), expv());
      end
      checks++;
      if (pack_reads(rd_log) !== pack_reads(exp_reads)) begin
        errors++; $display("FAIL random_reads_%0d: got %h required %h", it, pack_reads(rd_log), pack_reads(exp_reads));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mbr();
    test_superfloppy();
    test_bad_signature();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fat32_mount_sequencer.md
FAT32_MOUNT_SEQUENCER -- requirements
Module: fat32_mount_sequencer

Interface
REQ-001 SHALL have parameter SECTOR_BYTES, default 512, expected bytes per sector and stream length.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum idle clocks between stream bytes.
REQ-003 SHALL have ports, in this order:
- Clock  input  1  system clock, rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a mount.
- rd_req  output  1  sector read request.
- rd_sector  output  32  sector LBA to read.
- rd_ack  input  1  reader accepts the request.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  sector byte, ascending offset order.
- busy  output  1  mount in progress.
- mounted  output  1  geometry valid, level.
- mount_error  output  1  mount failed, level.
- error_code  output  3  failure cause.
- partition_lba  output  32  volume boot sector LBA.
- fat_start_sector  output  32  first FAT sector.
- data_start_sector  output  32  first data/cluster-2 sector.
- root_cluster  output  32  root directory cluster.
- sectors_per_cluster  output  8  cluster size in sectors.

Function
REQ-004 SHALL implement states IDLE, REQ_S0, RX_S0, CHK_S0, REQ_VBR, RX_VBR, CHK_VBR, CALC, DONE, ERR.
REQ-005 IDLE/DONE/ERR + start -> REQ_S0. Entry clears mounted, mount_error and error_code, and sets busy. start in any other state SHALL be ignored.
REQ-006 REQ_* states: rd_req=1 with rd_sector stable (REQ_S0: 0; REQ_VBR: partition_lba) until the cycle rd_ack=1 is sampled. The next state is RX_*, with rd_req=0 from that edge.
REQ-007 RX_* states: 10-bit offset counter starts at 0 and increments on each byte_valid. The byte at offset SECTOR_BYTES-1 moves the FSM to CHK_*. byte_valid outside RX_* SHALL be ignored.
REQ-008 RX_* states: idle counter resets on each byte_valid. Reaching TIMEOUT_CYCLES -> ERR, code 4.
REQ-009 RX_S0 SHALL capture:
- offset 0x000 (jump byte).
- 0x1C2 (partition type).
- 0x1C6-0x1C9 (LBA, little-endian).
- 0x1FE/0x1FF (signature).
REQ-010 CHK_S0 SHALL decide, in priority order:
- signature != 0x55,0xAA -> ERR code 1.
- type 0x0B or 0x0C -> partition_lba = captured LBA, go to REQ_VBR.
- jump byte 0xEB or 0xE9 -> superfloppy: partition_lba = 0, reuse the VBR fields captured in the same pass, go to CHK_VBR.
- otherwise -> ERR code 2.
REQ-011 RX_VBR (and the RX_S0 pass) SHALL capture, all little-endian:
- 0x0B-0x0C bytes/sector.
- 0x0D sectors/cluster.
- 0x0E-0x0F reserved sectors.
- 0x10 num FATs.
- 0x24-0x27 FAT size.
- 0x2C-0x2F root cluster.
- 0x1FE/0x1FF signature.
REQ-012 CHK_VBR SHALL check, in priority order:
- bad signature -> code 1.
- bytes/sector != SECTOR_BYTES -> code 3.
- sectors/cluster == 0 or num FATs == 0 -> code 5.
- otherwise -> CALC.
REQ-013 CALC SHALL last one cycle and compute, modulo 2^32:
- fat_start_sector = partition_lba + reserved.
- data_start_sector = fat_start_sector + num_fats*fat_size.
The FSM then goes to DONE with mounted=1, busy=0.
REQ-014 ERR SHALL set mount_error=1, busy=0, and hold error_code until the next start. Geometry outputs SHALL read 0 in ERR.
REQ-015 Geometry outputs SHALL update only at CALC and SHALL hold stable in DONE.
REQ-016 rd_ack while rd_req=0 SHALL be ignored.
REQ-017 A byte_valid arriving in the same cycle as the timeout threshold SHALL count as a byte; no timeout occurs.

Reset
REQ-018 sys_rst_n=0 SHALL force IDLE immediately, at any state including mid-stream.
REQ-019 Reset SHALL clear all outputs, counters and captured fields to 0.
REQ-020 After release, no read SHALL be issued until start.

Verification
REQ-021 MBR case: sector 0 with type 0x0C, LBA 0x00002000, sig 55AA; VBR with 512, spc 8, rsvd 32, 2 FATs, fatsz 0x3C1, root 2.
-> rd_sector 0 then 0x2000; fat_start 0x2020; data_start 0x27A2; mounted=1.
REQ-022 Superfloppy: sector 0 jump 0xEB, type 0x00, rsvd 32, 2 FATs, fatsz 0x100.
-> exactly one read; partition_lba 0; data_start 0x220.
REQ-023 Sector 0 ending 0x55,0x00 -> mount_error=1, code 1, no second rd_req.
REQ-024 Stream halts after 100 bytes for TIMEOUT_CYCLES -> code 4. A subsequent start -> clean remount succeeds.
REQ-025 sys_rst_n pulsed low at RX_VBR offset 300 -> all outputs 0, rd_req 0. A new start performs a full remount.
REQ-026 start pulsed during RX_S0, and rd_ack held high in IDLE -> no effect on sequence or outputs.
